// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions: format encodings, field positions,
// opcode constants and the writer FSM state type.
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2,
    FMT_X = 2'd3
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } wr_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMME_MSB  = 15;
  localparam int ADDR_MSB  = 25;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  // The only format code with no word layout is FMT_X.
  function automatic logic fmt_legal(input logic [1:0] fmt);
    return (fmt != FMT_X);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction fields plus format code -> 32-bit MIPS word.
// Fields not belonging to the selected format are ignored; an illegal format yields zero.
module instr_pack
  import mips_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imme,
  input  logic [25:0] addr,
  output logic [31:0] word
);

  // Place each field of the selected format at its architectural bit position.
  always_comb begin
    word = 32'h0000_0000;
    case (fmt)
      FMT_R: begin
        word[OP_MSB:OP_LSB]       = op;
        word[RS_MSB:RS_LSB]       = rs;
        word[RT_MSB:RT_LSB]       = rt;
        word[RD_MSB:RD_LSB]       = rd;
        word[SHAMT_MSB:SHAMT_LSB] = shamt;
        word[FUNC_MSB:FUNC_LSB]   = func;
      end
      FMT_I: begin
        word[OP_MSB:OP_LSB] = op;
        word[RS_MSB:RS_LSB] = rs;
        word[RT_MSB:RT_LSB] = rt;
        word[IMME_MSB:0]    = imme;
      end
      FMT_J: begin
        word[OP_MSB:OP_LSB] = op;
        word[ADDR_MSB:0]    = addr;
      end
      default: word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/im_writer.sv
// Instruction-memory write side: accepts field-level instructions, writes packed words
// to consecutive word indices and reads each back to verify it before accepting the next.
module im_writer
  import mips_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_func,
  input  logic [15:0]       in_imme,
  input  logic [25:0]       in_addr,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W-1:0] im_raddr,
  input  logic [31:0]       im_rdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_fmt,
  output logic              err_ovf,
  output logic              err_cmp
);

  localparam logic [ADDR_W-1:0] BASE_IDX = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  wr_state_e         state_r, next_state_s;
  logic [ADDR_W-1:0] ptr_r, raddr_r;
  logic [ADDR_W:0]   count_r;
  logic [31:0]       wdata_r, packed_s;
  logic              we_r, ready_r, done_r, last_r, full_r;
  logic              err_fmt_r, err_ovf_r, err_cmp_r;
  logic              hs_s, we_s, ready_s, done_s;

  instr_pack u_pack (
    .fmt   (in_fmt),
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .func  (in_func),
    .imme  (in_imme),
    .addr  (in_addr),
    .word  (packed_s)
  );

  assign hs_s = in_valid & ready_r & (state_r == ST_ACCEPT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start overrides everything, including a pending handshake.
  always_comb begin
    next_state_s = state_r;
    if (start) begin
      next_state_s = ST_ACCEPT;
    end else begin
      case (state_r)
        ST_IDLE:   next_state_s = ST_IDLE;
        ST_ACCEPT: begin
          if (hs_s) begin
            // full_r means the last slot already holds a word: no room for this one
            if (!fmt_legal(in_fmt) || full_r) begin
              next_state_s = ST_ERROR;
            end else begin
              next_state_s = ST_WRITE;
            end
          end else begin
            next_state_s = ST_ACCEPT;
          end
        end
        ST_WRITE:  next_state_s = ST_CHECK;
        ST_CHECK:  next_state_s = last_r ? ST_DONE : ST_ACCEPT;
        ST_DONE:   next_state_s = ST_DONE;
        ST_ERROR:  next_state_s = ST_ERROR;
        default:   next_state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered handshake/strobe outputs.
  always_comb begin
    ready_s = 1'b0;
    we_s    = 1'b0;
    done_s  = 1'b0;
    if (next_state_s == ST_ACCEPT) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (hs_s && (next_state_s == ST_WRITE)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
    if (next_state_s == ST_DONE) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Output, pointer, counter and sticky flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r   <= 1'b0;
      we_r      <= 1'b0;
      ptr_r     <= BASE_IDX;
      raddr_r   <= BASE_IDX;
      wdata_r   <= 32'h0000_0000;
      count_r   <= '0;
      done_r    <= 1'b0;
      last_r    <= 1'b0;
      full_r    <= 1'b0;
      err_fmt_r <= 1'b0;
      err_ovf_r <= 1'b0;
      err_cmp_r <= 1'b0;
    end else begin
      ready_r <= ready_s;
      we_r    <= we_s;
      if (start) begin
        ptr_r     <= BASE_IDX;
        raddr_r   <= BASE_IDX;
        count_r   <= '0;
        done_r    <= 1'b0;
        last_r    <= 1'b0;
        full_r    <= 1'b0;
        err_fmt_r <= 1'b0;
        err_ovf_r <= 1'b0;
        err_cmp_r <= 1'b0;
      end else begin
        done_r <= done_r | done_s;
        if (we_s) begin
          wdata_r <= packed_s;
          last_r  <= in_last;
        end
        if (hs_s && !fmt_legal(in_fmt)) begin
          err_fmt_r <= 1'b1;
        end
        if (hs_s && fmt_legal(in_fmt) && full_r) begin
          err_ovf_r <= 1'b1;
        end
        if (state_r == ST_WRITE) begin
          raddr_r <= ptr_r;
        end
        if (state_r == ST_CHECK) begin
          if (im_rdata != wdata_r) begin
            err_cmp_r <= 1'b1;
          end
          count_r <= count_r + (ADDR_W+1)'(1);
          // the pointer parks on the last index instead of wrapping
          if (ptr_r == LAST_IDX) begin
            full_r <= 1'b1;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign in_ready = ready_r;
  assign im_we    = we_r;
  assign im_waddr = ptr_r;
  assign im_wdata = wdata_r;
  assign im_raddr = raddr_r;
  assign count    = count_r;
  assign done     = done_r;
  assign err_fmt  = err_fmt_r;
  assign err_ovf  = err_ovf_r;
  assign err_cmp  = err_cmp_r;

endmodule

// File: tb/tb_im_writer.sv
// Randomized self-checking bench for im_writer against a transaction-level model
// (arithmetic word packing, running pointer/count/flag bookkeeping, behavioural IM array).
module tb_im_writer;
  import mips_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_fmt = 2'd0;
  logic [5:0]        in_op = 6'd0;
  logic [4:0]        in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [5:0]        in_func = 6'd0;
  logic [15:0]       in_imme = 16'd0;
  logic [25:0]       in_addr = 26'd0;
  logic              in_last = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr, im_raddr;
  logic [31:0]       im_wdata, im_rdata;
  logic [ADDR_W:0]   count;
  logic              done, err_fmt, err_ovf, err_cmp;

  im_writer #(.ADDR_W(ADDR_W), .BASE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_func(in_func), .in_imme(in_imme), .in_addr(in_addr),
    .in_last(in_last), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .im_raddr(im_raddr), .im_rdata(im_rdata), .count(count), .done(done),
    .err_fmt(err_fmt), .err_ovf(err_ovf), .err_cmp(err_cmp)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory with an optional read-data corruption.
  logic [31:0] mem [0:DEPTH-1];
  logic        corrupt = 1'b0;
  always @(posedge clk) if (im_we) mem[im_waddr] <= im_wdata;
  assign im_rdata = corrupt ? (mem[im_raddr] ^ 32'h0000_0100) : mem[im_raddr];

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state, advanced per instruction rather than per cycle.
  int m_ptr, m_count;
  bit m_full, m_done, m_ecmp, m_efmt, m_eovf;
  logic [31:0] seen_wdata;

  function automatic logic [31:0] ref_word(input int fmt, input int op, input int rs,
      input int rt, input int rd, input int sh, input int fn, input int imme, input int addr);
    longint unsigned w;
    case (fmt)
      0: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + sh * 64'd64 + fn;
      1: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imme;
      2: w = op * 64'd67108864 + addr;
      default: w = 64'd0;
    endcase
    return w[31:0];
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_count = 0;
    m_full = 0; m_done = 0; m_ecmp = 0; m_efmt = 0; m_eovf = 0;
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_count"}, count, m_count);
    check_eq({tag, "_done"}, done, m_done);
    check_eq({tag, "_errcmp"}, err_cmp, m_ecmp);
    check_eq({tag, "_errfmt"}, err_fmt, m_efmt);
    check_eq({tag, "_errovf"}, err_ovf, m_eovf);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check_eq("start_ready", in_ready, 1);
    check_eq("start_waddr", im_waddr, 0);
    check_eq("start_we", im_we, 0);
    check_flags("start");
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) check_eq("ready_timeout", 0, 1);
  endtask

  task automatic set_fields(input int fmt, input int op, input int rs, input int rt,
      input int rd, input int sh, input int fn, input int imme, input int addr, input bit last);
    in_fmt = 2'(fmt); in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_func = 6'(fn); in_imme = 16'(imme); in_addr = 26'(addr);
    in_last = last;
  endtask

  // One full instruction transaction with checks at hs+1, hs+2 and hs+3.
  task automatic drive_instr(input int fmt, input int op, input int rs, input int rt,
      input int rd, input int sh, input int fn, input int imme, input int addr,
      input bit last, input bit bad_rd);
    bit ok;
    logic [31:0] exp;
    wait_ready(ok);
    if (!ok) return;
    set_fields(fmt, op, rs, rt, rd, sh, fn, imme, addr, last);
    in_valid = 1'b1;
    exp = ref_word(fmt, op, rs, rt, rd, sh, fn, imme, addr);
    @(negedge clk);
    in_valid = 1'b0;
    seen_wdata = im_wdata;
    if (fmt == 3) begin
      m_efmt = 1;
      check_eq("fmt_we", im_we, 0);
      check_eq("fmt_ready", in_ready, 0);
      check_eq("fmt_waddr", im_waddr, m_ptr);
      check_flags("fmt");
      return;
    end
    if (m_full) begin
      m_eovf = 1;
      check_eq("ovf_we", im_we, 0);
      check_eq("ovf_ready", in_ready, 0);
      check_eq("ovf_waddr", im_waddr, m_ptr);
      check_flags("ovf");
      return;
    end
    check_eq("w_we", im_we, 1);
    check_eq("w_waddr", im_waddr, m_ptr);
    check_eq("w_wdata", im_wdata, exp);
    check_eq("w_ready", in_ready, 0);
    corrupt = bad_rd;
    @(negedge clk);
    check_eq("c_we", im_we, 0);
    check_eq("c_raddr", im_raddr, m_ptr);
    check_eq("c_mem", mem[m_ptr], exp);
    @(negedge clk);
    corrupt = 1'b0;
    m_count++;
    if (bad_rd) m_ecmp = 1;
    if (m_ptr == DEPTH - 1) m_full = 1;
    else m_ptr++;
    if (last) m_done = 1;
    check_eq("e_ready", in_ready, !last);
    check_eq("e_waddr", im_waddr, m_ptr);
    check_flags("e");
  endtask

  task automatic drive_rand(input int fmt, input bit last, input bit bad_rd);
    drive_instr(fmt, $urandom_range(63, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(63, 0),
                $urandom_range(65535, 0), $urandom & 32'h03ff_ffff, last, bad_rd);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, in_ready, 0);
    check_eq({tag, "_we"}, im_we, 0);
    check_eq({tag, "_waddr"}, im_waddr, 0);
    check_eq({tag, "_wdata"}, im_wdata, 0);
    check_eq({tag, "_raddr"}, im_raddr, 0);
    model_clear();
    check_flags(tag);
  endtask

  initial begin
    bit ok;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", in_ready, 0);
    pulse_start();

    // Directed words: addu, ori, j with in_last on the third.
    drive_instr(0, 0, 1, 2, 3, 0, 33, 16'hffff, 26'h3ff_ffff, 1'b0, 1'b0);
    check_eq("addu_word", seen_wdata, 32'h0022_1821);
    drive_instr(1, 13, 0, 1, 31, 31, 63, 16'h1234, 26'h3ff_ffff, 1'b0, 1'b0);
    check_eq("ori_word", seen_wdata, 32'h3401_1234);
    drive_instr(2, 2, 31, 31, 31, 31, 63, 16'hffff, 26'h000_0c03, 1'b1, 1'b0);
    check_eq("j_word", seen_wdata, 32'h0800_0c03);
    repeat (3) @(negedge clk);
    check_eq("done_hold_ready", in_ready, 0);
    check_eq("done_hold_we", im_we, 0);
    check_flags("done_hold");

    // Random stream with occasional read-back corruption.
    pulse_start();
    for (int i = 0; i < 20; i++)
      drive_rand($urandom_range(2, 0), i == 19, ($urandom_range(4, 0) == 0));

    // start during WRITE aborts and clears.
    pulse_start();
    drive_rand(0, 1'b0, 1'b1);
    drive_rand(1, 1'b0, 1'b0);
    wait_ready(ok);
    set_fields(2, 2, 0, 0, 0, 0, 0, 0, 26'h155, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("abort_we_in_write", im_we, 1);
    pulse_start();
    @(negedge clk);
    check_eq("abort_no_we", im_we, 0);
    drive_rand(1, 1'b0, 1'b0);

    // Illegal format -> ERROR, no write, sticks until start.
    drive_rand(3, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_eq("err_hold_we", im_we, 0);
      check_eq("err_hold_ready", in_ready, 0);
    end
    check_flags("err_hold");

    // Fill every word, then one more.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) drive_rand($urandom_range(2, 0), 1'b0, 1'b0);
    check_eq("fill_count", count, DEPTH);
    drive_rand(0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("ovf_hold_waddr", im_waddr, DEPTH - 1);
    check_eq("ovf_hold_we", im_we, 0);

    // Asynchronous reset in the middle of CHECK.
    pulse_start();
    drive_rand(0, 1'b0, 1'b0);
    wait_ready(ok);
    set_fields(1, 13, 3, 4, 0, 0, 0, 16'h5a5a, 0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("arst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("arst_idle_ready", in_ready, 0);
    pulse_start();
    drive_rand(2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
